// File: rtl/cpu_lsu_if.sv
// Purpose: memory-side bus between the load/store unit and the data memory.
// Signals:
//   bus_req_valid / bus_req_ready  request handshake (master -> slave / slave -> master)
//   bus_addr                       word-aligned byte address
//   bus_we, bus_wstrb, bus_wdata   write enable, byte-lane strobes, lane-placed store data
//   bus_resp_valid, bus_rdata      response strobe (loads and stores) and load data word
// Modports: master (LSU side), slave (memory side).
interface cpu_lsu_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
        input  bus_req_ready, bus_resp_valid, bus_rdata
    );

    modport slave (
        input  bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata,
        output bus_req_ready, bus_resp_valid, bus_rdata
    );
endinterface

// File: rtl/cpu_lsu.sv
// Purpose: load/store unit. Takes one load or store from the execute stage,
// rejects illegal or misaligned requests with an exception pulse, otherwise
// runs a single bus transaction (request handshake, then response) and
// returns the extended load result together with a one-cycle done pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_*_i                  request from execute (valid, addr, wdata, store mask, load funct3)
//   busy_o                   stall request while a transaction is in flight
//   done_o, rdata_o          completion pulse and load result
//   exc_valid_o/cause_o/tval_o  rejection pulse, cause code, faulting address
//   bus                      memory bus (master side)
module cpu_lsu (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    input  logic [31:0]     req_addr_i,
    input  logic [31:0]     req_wdata_i,
    input  logic [3:0]      req_mem_write_i,
    input  logic [2:0]      req_ext_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [31:0]     rdata_o,
    output logic            exc_valid_o,
    output logic [3:0]      exc_cause_o,
    output logic [31:0]     exc_tval_o,
    cpu_lsu_if.master       bus
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 4;

    localparam logic [CW-1:0] CAUSE_NONE    = 4'd0;
    localparam logic [CW-1:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [CW-1:0] CAUSE_LD_MIS  = 4'd4;
    localparam logic [CW-1:0] CAUSE_ST_MIS  = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t          state_q;
    logic            busy_q, done_q, exc_valid_q;
    logic [XLEN-1:0] rdata_q, exc_tval_q;
    logic [CW-1:0]   exc_cause_q;
    logic            bus_req_valid_q, bus_we_q;
    logic [XLEN-1:0] bus_addr_q, bus_wdata_q;
    logic [3:0]      bus_wstrb_q;
    logic [1:0]      addr_lo_q;
    logic [2:0]      ext_q;

    // Request decode: access size, legality, alignment and lane placement.
    logic            is_load_d, size_half_d, size_word_d, misaligned_d;
    logic [CW-1:0]   exc_cause_d;
    logic [3:0]      wstrb_d;
    logic [XLEN-1:0] wdata_d;

    always_comb begin
        is_load_d    = (req_mem_write_i == 4'b0000);
        size_half_d  = 1'b0;
        size_word_d  = 1'b0;
        wstrb_d      = 4'b0000;
        wdata_d      = '0;
        exc_cause_d  = CAUSE_NONE;

        if (is_load_d) begin
            size_half_d = (req_ext_i[1:0] == 2'b01);
            size_word_d = (req_ext_i[1:0] == 2'b10);
        end else begin
            size_half_d = (req_mem_write_i == 4'b0011);
            size_word_d = (req_mem_write_i == 4'b1111);
        end
        misaligned_d = (size_half_d && req_addr_i[0]) ||
                       (size_word_d && (req_addr_i[1:0] != 2'b00));

        // Illegal encodings take precedence over alignment faults.
        if (!(req_mem_write_i inside {4'b0000, 4'b0001, 4'b0011, 4'b1111}) ||
            (is_load_d && !(req_ext_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})))
            exc_cause_d = CAUSE_ILLEGAL;
        else if (misaligned_d)
            exc_cause_d = is_load_d ? CAUSE_LD_MIS : CAUSE_ST_MIS;

        if (!is_load_d) begin
            wstrb_d = req_mem_write_i << req_addr_i[1:0];
            if (size_word_d)
                wdata_d = req_wdata_i;
            else if (size_half_d)
                wdata_d = {2{req_wdata_i[15:0]}};
            else
                wdata_d = {4{req_wdata_i[7:0]}};
        end
    end

    // Load extraction from the returned word using the latched offset and funct3.
    logic [7:0]      ld_byte_d;
    logic [15:0]     ld_half_d;
    logic [XLEN-1:0] ld_data_d;

    always_comb begin
        ld_byte_d = bus.bus_rdata[7:0];
        case (addr_lo_q)
            2'd1:    ld_byte_d = bus.bus_rdata[15:8];
            2'd2:    ld_byte_d = bus.bus_rdata[23:16];
            2'd3:    ld_byte_d = bus.bus_rdata[31:24];
            default: ld_byte_d = bus.bus_rdata[7:0];
        endcase
        ld_half_d = addr_lo_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (ext_q)
            3'b000:  ld_data_d = {{24{ld_byte_d[7]}}, ld_byte_d};
            3'b001:  ld_data_d = {{16{ld_half_d[15]}}, ld_half_d};
            3'b100:  ld_data_d = {24'd0, ld_byte_d};
            3'b101:  ld_data_d = {16'd0, ld_half_d};
            default: ld_data_d = bus.bus_rdata;
        endcase
    end

    // Transaction FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            rdata_q         <= '0;
            exc_valid_q     <= 1'b0;
            exc_cause_q     <= '0;
            exc_tval_q      <= '0;
            bus_req_valid_q <= 1'b0;
            bus_addr_q      <= '0;
            bus_we_q        <= 1'b0;
            bus_wstrb_q     <= '0;
            bus_wdata_q     <= '0;
            addr_lo_q       <= '0;
            ext_q           <= '0;
        end else begin
            done_q      <= 1'b0;
            exc_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (exc_cause_d != CAUSE_NONE) begin
                            exc_valid_q <= 1'b1;
                            exc_cause_q <= exc_cause_d;
                            exc_tval_q  <= req_addr_i;
                        end else begin
                            state_q         <= S_REQ;
                            busy_q          <= 1'b1;
                            bus_req_valid_q <= 1'b1;
                            bus_addr_q      <= {req_addr_i[31:2], 2'b00};
                            bus_we_q        <= !is_load_d;
                            bus_wstrb_q     <= wstrb_d;
                            bus_wdata_q     <= wdata_d;
                            addr_lo_q       <= req_addr_i[1:0];
                            ext_q           <= req_ext_i;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.bus_req_ready) begin
                        bus_req_valid_q <= 1'b0;
                        state_q         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.bus_resp_valid) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        rdata_q <= bus_we_q ? '0 : ld_data_d;
                    end
                end
                default: begin
                    state_q         <= S_IDLE;
                    busy_q          <= 1'b0;
                    bus_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign rdata_o           = rdata_q;
    assign exc_valid_o       = exc_valid_q;
    assign exc_cause_o       = exc_cause_q;
    assign exc_tval_o        = exc_tval_q;
    assign bus.bus_req_valid = bus_req_valid_q;
    assign bus.bus_addr      = bus_addr_q;
    assign bus.bus_we        = bus_we_q;
    assign bus.bus_wstrb     = bus_wstrb_q;
    assign bus.bus_wdata     = bus_wdata_q;

endmodule

// File: tb/tb_cpu_lsu.sv
// Purpose: self-checking bench for cpu_lsu. Directed scenarios plus randomized
// requests against a size/offset arithmetic reference model.
module tb_cpu_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_mem_write;
    logic [2:0]  req_ext;
    logic        busy, done, exc_valid;
    logic [31:0] rdata, exc_tval;
    logic [3:0]  exc_cause;
    int          tests = 0;
    int          fails = 0;

    cpu_lsu_if bus_if ();

    cpu_lsu dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .req_addr_i      (req_addr),
        .req_wdata_i     (req_wdata),
        .req_mem_write_i (req_mem_write),
        .req_ext_i       (req_ext),
        .busy_o          (busy),
        .done_o          (done),
        .rdata_o         (rdata),
        .exc_valid_o     (exc_valid),
        .exc_cause_o     (exc_cause),
        .exc_tval_o      (exc_tval),
        .bus             (bus_if)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int access_bytes(input logic [3:0] mw, input logic [2:0] ext);
        if (mw == 4'b0000) return (ext % 4 == 0) ? 1 : (ext % 4 == 1) ? 2 : 4;
        return (mw == 4'b0001) ? 1 : (mw == 4'b0011) ? 2 : 4;
    endfunction

    function automatic logic [3:0] model_cause(input logic [3:0] mw, input logic [2:0] ext,
                                               input logic [31:0] addr);
        int n;
        if (!(mw == 0 || mw == 1 || mw == 3 || mw == 15)) return 4'd2;
        if (mw == 0 && (ext == 3 || ext == 6 || ext == 7)) return 4'd2;
        n = access_bytes(mw, ext);
        if (addr % n != 0) return (mw == 0) ? 4'd4 : 4'd6;
        return 4'd0;
    endfunction

    function automatic logic [3:0] model_wstrb(input int n, input logic [31:0] addr);
        int v;
        v = ((1 << n) - 1) << (addr % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int n);
        logic [31:0] r;
        r = 0;
        for (int lane = 0; lane < 4; lane++)
            r |= ((wd >> (8 * (lane % n))) & 32'hFF) << (8 * lane);
        return r;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] word, input logic [31:0] addr,
                                                input logic [2:0] ext);
        longint v;
        int n;
        n = access_bytes(4'b0000, ext);
        v = longint'((word >> (8 * (addr % 4))) & ((n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1)));
        if (ext < 4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    // ---------------- scenario tasks ----------------
    task automatic idle_cycle();
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] mw,
                           input logic [2:0] ext, input int rdly, input int sdly,
                           input logic [31:0] word, input bit noise, input string tag);
        int n;
        logic store;
        logic [31:0] wmask, exp_rd;
        logic [69:0] exp_bus, got_bus;
        n = access_bytes(mw, ext);
        store = (mw != 4'b0000);
        wmask = store ? 32'hFFFF_FFFF : 32'h0;
        exp_rd = store ? 32'h0 : model_rdata(word, addr, ext);
        exp_bus = {1'b1, addr & 32'hFFFF_FFFC, store, store ? model_wstrb(n, addr) : 4'b0000,
                   store ? model_wdata(wd, n) : 32'h0};
        req_valid = 1'b1; req_addr = addr; req_wdata = wd; req_mem_write = mw; req_ext = ext;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests++;
        if ({bus_if.bus_req_valid, busy, done, exc_valid} !== 4'b1100) begin
            fails++;
            $display("FAIL %s accept: {req_valid,busy,done,exc}=%b expected 1100", tag,
                     {bus_if.bus_req_valid, busy, done, exc_valid});
        end
        for (int i = 0; i <= rdly; i++) begin
            got_bus = {bus_if.bus_req_valid, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wstrb,
                       bus_if.bus_wdata & wmask};
            tests++;
            if (got_bus !== exp_bus || busy !== 1'b1 || exc_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s bus_fields cyc%0d: got %h busy=%b exc=%b expected %h busy=1 exc=0",
                         tag, i, got_bus, busy, exc_valid, exp_bus);
            end
            if (i == rdly) break;
            if (noise) begin
                req_valid = 1'b1; req_addr = $urandom; req_wdata = $urandom;
                req_mem_write = 4'($urandom); req_ext = 3'($urandom);
            end
            bus_if.bus_req_ready = 1'b0;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        bus_if.bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_req_ready = 1'b0;
        tests++;
        if ({bus_if.bus_req_valid, busy, done} !== 3'b010) begin
            fails++;
            $display("FAIL %s handshake: {req_valid,busy,done}=%b expected 010", tag,
                     {bus_if.bus_req_valid, busy, done});
        end
        for (int i = 0; i < sdly; i++) begin
            if (noise) begin
                req_valid = 1'b1; req_addr = $urandom; req_mem_write = 4'($urandom);
            end
            @(posedge clk); #1;
            tests++;
            if ({busy, done, exc_valid} !== 3'b100) begin
                fails++;
                $display("FAIL %s wait cyc%0d: {busy,done,exc}=%b expected 100", tag, i,
                         {busy, done, exc_valid});
            end
        end
        req_valid = 1'b0;
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata = word;
        @(posedge clk); #1;
        bus_if.bus_resp_valid = 1'b0;
        bus_if.bus_rdata = $urandom;
        tests++;
        if ({done, busy, exc_valid} !== 3'b100 || rdata !== exp_rd) begin
            fails++;
            $display("FAIL %s done: {done,busy,exc}=%b rdata=%h expected 100 rdata=%h", tag,
                     {done, busy, exc_valid}, rdata, exp_rd);
        end
    endtask

    task automatic run_exc(input logic [31:0] addr, input logic [3:0] mw, input logic [2:0] ext,
                           input logic [3:0] cause, input string tag);
        req_valid = 1'b1; req_addr = addr; req_wdata = $urandom; req_mem_write = mw; req_ext = ext;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests++;
        if ({exc_valid, busy, done, bus_if.bus_req_valid} !== 4'b1000 ||
            exc_cause !== cause || exc_tval !== addr) begin
            fails++;
            $display("FAIL %s exc: {exc,busy,done,req_valid}=%b cause=%0d tval=%h expected 1000 cause=%0d tval=%h",
                     tag, {exc_valid, busy, done, bus_if.bus_req_valid}, exc_cause, exc_tval, cause, addr);
        end
        @(posedge clk); #1;
        tests++;
        if ({exc_valid, busy, bus_if.bus_req_valid} !== 3'b000) begin
            fails++;
            $display("FAIL %s exc_after: {exc,busy,req_valid}=%b expected 000", tag,
                     {exc_valid, busy, bus_if.bus_req_valid});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, exc_valid, bus_if.bus_req_valid, rdata, exc_cause, exc_tval} !== '0) begin
            fails++;
            $display("FAIL reset_values: busy=%b done=%b exc=%b req_valid=%b rdata=%h cause=%0d tval=%h expected all 0",
                     busy, done, exc_valid, bus_if.bus_req_valid, rdata, exc_cause, exc_tval);
        end
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic test_lb();
        run_txn(32'h0000_1003, 32'h0, 4'b0000, 3'b000, 0, 0, 32'h80FF_FFFF, 1'b0, "lb_1003");
        @(posedge clk); #1;
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL lb_done_pulse: done=%b expected 0", done);
        end
    endtask

    task automatic test_sh();
        run_txn(32'h0000_2002, 32'h0000_ABCD, 4'b0011, 3'b000, 1, 2, 32'h1234_5678, 1'b0, "sh_2002");
        idle_cycle();
    endtask

    task automatic test_misaligned();
        run_exc(32'h0000_3001, 4'b0000, 3'b010, 4'd4, "lw_3001");
        run_exc(32'h0000_3003, 4'b0011, 3'b000, 4'd6, "sh_3003");
        run_exc(32'h0000_3000, 4'b0000, 3'b110, 4'd2, "ld_ext110");
        run_exc(32'h0000_3000, 4'b0111, 3'b000, 4'd2, "st_mask0111");
    endtask

    task automatic test_stall();
        run_txn(32'h0000_7004, 32'hDEAD_BEEF, 4'b1111, 3'b000, 5, 2, 32'h0, 1'b1, "sw_stall");
        idle_cycle();
        tests++;
        if ({bus_if.bus_req_valid, busy, exc_valid} !== 3'b000) begin
            fails++;
            $display("FAIL stall_ignored_req: {req_valid,busy,exc}=%b expected 000",
                     {bus_if.bus_req_valid, busy, exc_valid});
        end
    endtask

    task automatic test_back_to_back();
        run_txn(32'h0000_4002, 32'h0, 4'b0000, 3'b101, 0, 0, 32'h8001_0000, 1'b0, "lhu_4002");
        run_txn(32'h0000_5000, 32'hCAFE_F00D, 4'b1111, 3'b000, 0, 0, 32'h0, 1'b0, "sw_b2b");
        idle_cycle();
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_addr = 32'h0000_6000; req_mem_write = 4'b0000; req_ext = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        bus_if.bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({busy, done, exc_valid, bus_if.bus_req_valid, rdata, exc_cause, exc_tval} !== '0) begin
            fails++;
            $display("FAIL rst_mid_values: busy=%b done=%b exc=%b req_valid=%b rdata=%h",
                     busy, done, exc_valid, bus_if.bus_req_valid, rdata);
        end
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        bus_if.bus_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({busy, done, bus_if.bus_req_valid, rdata} !== '0) begin
                fails++;
                $display("FAIL rst_mid_late_resp cyc%0d: busy=%b done=%b req_valid=%b rdata=%h expected 0",
                         i, busy, done, bus_if.bus_req_valid, rdata);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [31:0] addr, wd;
        logic [3:0] mw, cause;
        logic [2:0] ext;
        int sel;
        for (int it = 0; it < 60; it++) begin
            sel = $urandom_range(0, 9);
            mw = (sel < 4) ? 4'b0000 : (sel < 6) ? 4'b0001 : (sel == 6) ? 4'b0011 :
                 (sel == 7) ? 4'b1111 : 4'($urandom);
            ext = 3'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wd = $urandom;
            cause = model_cause(mw, ext, addr);
            if (cause != 4'd0)
                run_exc(addr, mw, ext, cause, "rand_exc");
            else
                run_txn(addr, wd, mw, ext, $urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom, 1'($urandom), "rand_txn");
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_mem_write = '0; req_ext = '0;
        bus_if.bus_req_ready = 1'b0;
        bus_if.bus_resp_valid = 1'b0;
        bus_if.bus_rdata = '0;
        test_reset();
        test_lb();
        test_sh();
        test_misaligned();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
